// File: rtl/stack_game_pkg.sv
// Shared types and widths for the stacker game sequencer.
// Holds the FSM state encoding, the level counter width and a saturating increment helper.
package stack_game_pkg;

    localparam int STATE_W = 3;
    localparam int LEVEL_W = 5;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        DROP_WAIT = 3'd2,
        PAUSED    = 3'd3,
        WIN       = 3'd4,
        LOSE      = 3'd5
    } state_t;

    // Level counter stops at all-ones instead of wrapping to zero.
    function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
        return (lvl == '1) ? lvl : lvl + LEVEL_W'(1);
    endfunction

endpackage

// File: rtl/stack_game_ctrl_one_hz_divider.sv
// Divides the master clock down to a registered 50%-duty 1 Hz clock.
// clear zeroes count and output; run=0 with clear=0 freezes both mid-period.
module one_hz_divider #(
    parameter int CLK_FREQ_HZ = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic one_hz_clk
);

    localparam int HALF  = CLK_FREQ_HZ / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0] r_count;
    logic             r_one_hz;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_one_hz <= 1'b0;
        end else if (clear) begin
            r_count  <= '0;
            r_one_hz <= 1'b0;
        end else if (run) begin
            if (r_count == CNT_W'(HALF - 1)) begin
                r_count  <= '0;
                r_one_hz <= ~r_one_hz;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign one_hz_clk = r_one_hz;

endmodule

// File: rtl/stack_game_ctrl.sv
// Game sequencer for the stacker: owns the countdown timer controls, the drop
// request/acknowledge handshake with the stacking engine, and the win/lose decision.
module stack_game_ctrl
    import stack_game_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int MAX_LEVEL   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               btn_drop,
    input  logic               timer_end,
    input  logic               drop_ack,
    input  logic               drop_hit,
    output logic               one_hz_clk,
    output logic               timer_rst,
    output logic               timer_pause,
    output logic               drop_req,
    output logic [LEVEL_W-1:0] level,
    output logic [STATE_W-1:0] state,
    output logic               win,
    output logic               lose
);

    state_t             r_state;
    logic [LEVEL_W-1:0] r_level;
    logic               r_timer_rst;
    logic               r_timer_pause;
    logic               r_drop_req;
    logic               r_win;
    logic               r_lose;
    logic               r_sync1;
    logic               r_sync2;

    logic [LEVEL_W-1:0] w_level_inc;
    logic               w_last_drop;
    logic               w_run;
    logic               w_stop;
    logic               w_clear;

    // timer_end comes from the one_hz_clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= timer_end;
            r_sync2 <= r_sync1;
        end
    end

    assign w_level_inc = level_inc(r_level);
    assign w_last_drop = (w_level_inc == LEVEL_W'(MAX_LEVEL));

    // Divider counts on the current state but clears on the transition edge into
    // IDLE/WIN/LOSE, so one_hz_clk is already low whenever those states are occupied.
    assign w_run   = (r_state == RUN) || (r_state == DROP_WAIT);
    assign w_stop  = ((r_state == RUN) && r_sync2)
                   || ((r_state == DROP_WAIT) && drop_ack && (!drop_hit || w_last_drop))
                   || ((r_state == PAUSED) && btn_start);
    assign w_clear = !(w_run || (r_state == PAUSED)) || w_stop;

    one_hz_divider #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .run       (w_run),
        .clear     (w_clear),
        .one_hz_clk(one_hz_clk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_level       <= '0;
            r_timer_rst   <= 1'b1;
            r_timer_pause <= 1'b1;
            r_drop_req    <= 1'b0;
            r_win         <= 1'b0;
            r_lose        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timer_rst   <= 1'b1;
                    r_timer_pause <= 1'b1;
                    r_drop_req    <= 1'b0;
                    r_win         <= 1'b0;
                    r_lose        <= 1'b0;
                    if (btn_start) begin
                        r_state       <= RUN;
                        r_level       <= '0;
                        r_timer_rst   <= 1'b0;
                        r_timer_pause <= 1'b0;
                    end
                end
                RUN: begin
                    if (r_sync2) begin
                        r_state       <= LOSE;
                        r_lose        <= 1'b1;
                        r_timer_pause <= 1'b1;
                    end else if (btn_pause) begin
                        r_state       <= PAUSED;
                        r_timer_pause <= 1'b1;
                    end else if (btn_drop) begin
                        r_state    <= DROP_WAIT;
                        r_drop_req <= 1'b1;
                    end
                end
                DROP_WAIT: begin
                    if (drop_ack) begin
                        r_drop_req <= 1'b0;
                        if (drop_hit) begin
                            r_level <= w_level_inc;
                            if (w_last_drop) begin
                                r_state       <= WIN;
                                r_win         <= 1'b1;
                                r_timer_pause <= 1'b1;
                            end else begin
                                r_state <= RUN;
                            end
                        end else begin
                            r_state       <= LOSE;
                            r_lose        <= 1'b1;
                            r_timer_pause <= 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (btn_start) begin
                        r_state     <= IDLE;
                        r_timer_rst <= 1'b1;
                    end else if (btn_pause) begin
                        r_state       <= RUN;
                        r_timer_pause <= 1'b0;
                    end
                end
                WIN, LOSE: begin
                    if (btn_start) begin
                        r_state     <= IDLE;
                        r_timer_rst <= 1'b1;
                        r_win       <= 1'b0;
                        r_lose      <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_timer_rst   <= 1'b1;
                    r_timer_pause <= 1'b1;
                    r_drop_req    <= 1'b0;
                    r_win         <= 1'b0;
                    r_lose        <= 1'b0;
                end
            endcase
        end
    end

    assign timer_rst   = r_timer_rst;
    assign timer_pause = r_timer_pause;
    assign drop_req    = r_drop_req;
    assign level       = r_level;
    assign state       = r_state;
    assign win         = r_win;
    assign lose        = r_lose;

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Directed bench for stack_game_ctrl: a game-rule model checked every cycle,
// plus literal expectations for timing points of each scenario.
module tb_stack_game_ctrl;

    localparam int FREQ = 20;
    localparam int HALF = FREQ / 2;
    localparam int MAXL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_drop = 1'b0;
    logic       timer_end = 1'b0;
    logic       drop_ack = 1'b0;
    logic       drop_hit = 1'b0;
    logic       one_hz_clk;
    logic       timer_rst;
    logic       timer_pause;
    logic       drop_req;
    logic [4:0] level;
    logic [2:0] state;
    logic       win;
    logic       lose;

    int n_checks = 0;
    int n_fail = 0;

    stack_game_ctrl #(
        .CLK_FREQ_HZ(FREQ),
        .MAX_LEVEL  (MAXL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .btn_drop   (btn_drop),
        .timer_end  (timer_end),
        .drop_ack   (drop_ack),
        .drop_hit   (drop_hit),
        .one_hz_clk (one_hz_clk),
        .timer_rst  (timer_rst),
        .timer_pause(timer_pause),
        .drop_req   (drop_req),
        .level      (level),
        .state      (state),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game-rule model: state names as plain numbers, timer progress as a count of
    // clock cycles spent with the timer running since the game started.
    localparam int S_IDLE = 0, S_RUN = 1, S_DW = 2, S_PAUSED = 3, S_WIN = 4, S_LOSE = 5;
    int m_state = S_IDLE;
    int m_level = 0;
    int m_ticks = 0;
    bit m_te_d1 = 0;
    bit m_te_d2 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = S_IDLE;
            m_level = 0;
            m_ticks = 0;
            m_te_d1 = 0;
            m_te_d2 = 0;
        end else begin
            bit seen_end;
            bit timing;
            int nxt;
            seen_end = m_te_d2;
            m_te_d2  = m_te_d1;
            m_te_d1  = timer_end;
            timing   = (m_state == S_RUN) || (m_state == S_DW);
            nxt      = m_state;
            case (m_state)
                S_IDLE: if (btn_start) begin nxt = S_RUN; m_level = 0; end
                S_RUN: begin
                    if (seen_end) nxt = S_LOSE;
                    else if (btn_pause) nxt = S_PAUSED;
                    else if (btn_drop) nxt = S_DW;
                end
                S_DW: if (drop_ack) begin
                    if (drop_hit) begin
                        if (m_level < 31) m_level = m_level + 1;
                        nxt = (m_level == MAXL) ? S_WIN : S_RUN;
                    end else begin
                        nxt = S_LOSE;
                    end
                end
                S_PAUSED: begin
                    if (btn_start) nxt = S_IDLE;
                    else if (btn_pause) nxt = S_RUN;
                end
                default: if (btn_start) nxt = S_IDLE;
            endcase
            if (timing) m_ticks = m_ticks + 1;
            if (nxt == S_IDLE || nxt == S_WIN || nxt == S_LOSE) m_ticks = 0;
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        check("cmp_state", 32'(state), m_state);
        check("cmp_level", 32'(level), m_level);
        check("cmp_one_hz", 32'(one_hz_clk), 32'((m_ticks / HALF) % 2));
        check("cmp_timer_rst", 32'(timer_rst), 32'(m_state == S_IDLE));
        check("cmp_timer_pause", 32'(timer_pause), 32'(!(m_state == S_RUN || m_state == S_DW)));
        check("cmp_drop_req", 32'(drop_req), 32'(m_state == S_DW));
        check("cmp_win", 32'(win), 32'(m_state == S_WIN));
        check("cmp_lose", 32'(lose), 32'(m_state == S_LOSE));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        btn_start = 1'b0;
        btn_pause = 1'b0;
        btn_drop  = 1'b0;
        drop_ack  = 1'b0;
        drop_hit  = 1'b0;
    endtask

    // Cycles until one_hz_clk changes; -1 when it does not change within bound.
    task automatic cycles_to_toggle(input int bound, output int n);
        logic v0;
        v0 = one_hz_clk;
        n  = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (one_hz_clk !== v0) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic frozen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_state", 32'(state), 0);
        check("rst_timer_rst", 32'(timer_rst), 1);
        check("rst_timer_pause", 32'(timer_pause), 1);
        check("rst_one_hz", 32'(one_hz_clk), 0);
        check("rst_drop_req", 32'(drop_req), 0);
        check("rst_level", 32'(level), 0);
        check("rst_win_lose", 32'({win, lose}), 0);

        // Scenario 1: start and 1 Hz cadence
        btn_start = 1'b1; tick();
        check("start_state", 32'(state), 1);
        check("start_timer_rst", 32'(timer_rst), 0);
        check("start_timer_pause", 32'(timer_pause), 0);
        cycles_to_toggle(3 * HALF, n);
        check("first_rise_cycles", n, 10);
        check("first_rise_level", 32'(one_hz_clk), 1);
        cycles_to_toggle(3 * HALF, n);
        check("first_fall_cycles", n, 10);
        cycles_to_toggle(3 * HALF, n);
        check("second_rise_cycles", n, 10);

        // Scenario 2: handshake and win
        btn_drop = 1'b1; tick();
        check("drop_req_set", 32'(drop_req), 1);
        check("drop_wait_state", 32'(state), 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) btn_drop = 1'b1;
            if (i == 2) btn_pause = 1'b1;
            if (i == 3) btn_start = 1'b1;
            tick();
        end
        check("drop_req_held", 32'(drop_req), 1);
        check("drop_wait_held", 32'(state), 2);
        drop_ack = 1'b1; drop_hit = 1'b1; tick();
        check("hit1_level", 32'(level), 1);
        check("hit1_state", 32'(state), 1);
        check("hit1_drop_req", 32'(drop_req), 0);
        for (int k = 2; k <= MAXL; k++) begin
            btn_drop = 1'b1; tick();
            drop_ack = 1'b1; drop_hit = 1'b1; tick();
        end
        check("win_state", 32'(state), 4);
        check("win_flag", 32'({win, lose}), 2);
        check("win_level", 32'(level), 3);
        check("win_timer_pause", 32'(timer_pause), 1);
        btn_start = 1'b1; tick();
        check("win_to_idle", 32'(state), 0);
        check("idle_timer_rst", 32'(timer_rst), 1);

        // Scenario 3: miss -> lose, level kept until next start
        btn_start = 1'b1; tick();
        check("restart_level", 32'(level), 0);
        btn_drop = 1'b1; tick();
        drop_ack = 1'b1; drop_hit = 1'b1; tick();
        btn_drop = 1'b1; tick();
        drop_ack = 1'b1; drop_hit = 1'b0; tick();
        check("miss_state", 32'(state), 5);
        check("miss_flag", 32'({win, lose}), 1);
        check("miss_level", 32'(level), 1);
        btn_start = 1'b1; tick();
        check("lose_to_idle", 32'(state), 0);
        check("lose_idle_timer_rst", 32'(timer_rst), 1);
        check("idle_level_kept", 32'(level), 1);
        btn_start = 1'b1; tick();
        check("level_cleared", 32'(level), 0);

        // Scenario 4: pause 4 cycles into a half-period
        cycles_to_toggle(3 * HALF, n);
        check("align_found", 32'(n > 0), 1);
        repeat (3) tick();
        btn_pause = 1'b1; tick();
        check("paused_state", 32'(state), 3);
        check("paused_timer_pause", 32'(timer_pause), 1);
        frozen = one_hz_clk;
        repeat (50) tick();
        check("paused_frozen", 32'(one_hz_clk), 32'(frozen));
        btn_pause = 1'b1; tick();
        check("resume_state", 32'(state), 1);
        check("resume_timer_pause", 32'(timer_pause), 0);
        cycles_to_toggle(3 * HALF, n);
        check("resume_toggle_cycles", n, 6);

        // Scenario 5: timer expiry latency and priority
        timer_end = 1'b1; tick();
        check("end_lat1", 32'(state), 1);
        tick();
        check("end_lat2", 32'(state), 1);
        tick();
        check("end_lat3", 32'(state), 5);
        btn_start = 1'b1; tick();
        timer_end = 1'b0;
        repeat (3) tick();
        btn_start = 1'b1; tick();
        check("restart2_state", 32'(state), 1);
        timer_end = 1'b1; tick(); tick();
        btn_pause = 1'b1; btn_drop = 1'b1; tick();
        check("end_priority_state", 32'(state), 5);
        check("end_priority_drop_req", 32'(drop_req), 0);
        btn_start = 1'b1; tick();
        timer_end = 1'b0;
        repeat (3) tick();

        // Scenario 6: async reset during DROP_WAIT
        btn_start = 1'b1; tick();
        btn_drop = 1'b1; tick();
        check("pre_rst_drop_req", 32'(drop_req), 1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 0);
        check("async_rst_drop_req", 32'(drop_req), 0);
        check("async_rst_timer", 32'({timer_rst, timer_pause}), 3);
        check("async_rst_one_hz", 32'(one_hz_clk), 0);
        rst = 1'b0;
        drop_ack = 1'b1; drop_hit = 1'b1; tick();
        check("late_ack_state", 32'(state), 0);
        check("late_ack_level", 32'(level), 0);
        check("late_ack_drop_req", 32'(drop_req), 0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_game_ctrl.md
Name: stack_game_ctrl

Overview:
- Top-level game sequencer for the stacker.
- Owns the 90-second countdown timer: generates its 1 Hz clock, drives its reset and pause inputs, and consumes its end-of-game flag.
- Arbitrates player button pulses against the stacking engine through a drop request/acknowledge handshake.
- Tracks stack level and declares win or lose.

Parameters:
- CLK_FREQ_HZ, 100000000, master clock frequency; the 1 Hz half-period is CLK_FREQ_HZ/2 cycles.
- MAX_LEVEL, 15, number of successful drops that wins the game (1..31).

Ports:
- clk  in  1  master clock
- rst  in  1  asynchronous active-high reset
- btn_start  in  1  single-cycle pulse, pre-debounced, clk domain
- btn_pause  in  1  single-cycle pulse, pre-debounced
- btn_drop  in  1  single-cycle pulse, pre-debounced
- timer_end  in  1  sticky end flag from countdown timer, one_hz_clk domain
- drop_ack  in  1  single-cycle pulse from stacking engine: drop resolved
- drop_hit  in  1  valid with drop_ack: 1 = block landed on stack
- one_hz_clk  out  1  registered 50%-duty 1 Hz clock to countdown timer
- timer_rst  out  1  registered reset to countdown timer
- timer_pause  out  1  registered pause to countdown timer
- drop_req  out  1  drop request to stacking engine
- level  out  5  successful drops this game
- state  out  3  current FSM state encoding
- win  out  1  high in WIN
- lose  out  1  high in LOSE

Behaviour:
Reset values:
- state = IDLE, timer_rst = 1, timer_pause = 1, one_hz_clk = 0, drop_req = 0, level = 0, win = 0, lose = 0.
- Divider count = 0, synchroniser flops = 0.

Synchronisation:
- timer_end passes through a 2-flop synchroniser; the FSM sees it 2 clk later (tsync).
- All outputs are registered; no combinational path from inputs to outputs.

States and encoding: IDLE = 0, RUN = 1, DROP_WAIT = 2, PAUSED = 3, WIN = 4, LOSE = 5.
- IDLE:
  - timer_rst = 1, timer_pause = 1; divider held at 0, one_hz_clk = 0.
  - btn_start -> RUN: level <= 0, timer_rst <= 0, timer_pause <= 0, divider starts from 0.
- RUN:
  - Priority tsync > btn_pause > btn_drop.
  - tsync -> LOSE.
  - btn_pause -> PAUSED.
  - btn_drop -> DROP_WAIT, drop_req <= 1.
- DROP_WAIT:
  - Timer keeps running; drop_req held high until drop_ack.
  - btn_pause, btn_drop, btn_start and tsync are ignored.
  - On drop_ack, drop_req <= 0 in the same transition, and:
    - drop_hit = 1 and level+1 == MAX_LEVEL -> level <= level+1, go to WIN.
    - drop_hit = 1 otherwise -> level <= level+1, go to RUN.
    - drop_hit = 0 -> LOSE, level unchanged.
  - If the timer expired during DROP_WAIT, RUN exits to LOSE on the next cycle because timer_end is sticky.
- PAUSED:
  - timer_pause = 1; divider count and one_hz_clk frozen, so no timer edges and the partial second is preserved.
  - btn_pause -> RUN, timer_pause <= 0.
  - btn_start -> IDLE (abort), timer_rst <= 1.
  - btn_start has priority if both arrive together.
- WIN and LOSE:
  - timer_pause = 1; divider held at 0, one_hz_clk = 0.
  - win or lose = 1 respectively.
  - btn_start -> IDLE, timer_rst <= 1.
- win and lose are never both high.

Divider:
- Active only in RUN and DROP_WAIT.
- Count wraps at CLK_FREQ_HZ/2 - 1 and toggles one_hz_clk on wrap.
- First rising edge comes CLK_FREQ_HZ/2 cycles after entering RUN from IDLE.

Other rules:
- level saturates at 31; it is unreachable past MAX_LEVEL.
- timer_rst changes only while one_hz_clk = 0, which keeps the timer's async reset release clean.
- rst mid-game returns every output to its reset value asynchronously; any outstanding drop_ack is then ignored in IDLE.
- Unused state encodings -> IDLE.

Decomposition:
- Package stack_game_pkg:
  - State encoding constants IDLE..LOSE and the 3-bit state width.
  - Level width of 5.
- Sub-module one_hz_divider, parameter CLK_FREQ_HZ, ports:
  - clk, rst
  - run: count and toggle
  - clear: zero count and output, priority over run
  - one_hz_clk
- Freezing is run = 0 with clear = 0.

Test Plan:
All scenarios use CLK_FREQ_HZ = 20 (half-period 10 cycles) and MAX_LEVEL = 3.
1. Reset, then btn_start -> next cycle state = RUN, timer_rst = 0, timer_pause = 0; first one_hz_clk rise exactly 10 cycles later; edges every 10 cycles thereafter.
2. In RUN, btn_drop -> drop_req = 1. Hold drop_ack low 5 cycles: drop_req stays 1 and extra btn_drop pulses are ignored. Then ack with drop_hit = 1 -> level = 1, state = RUN, drop_req = 0. Three hits total -> state = WIN, win = 1, level = 3, timer_pause = 1.
3. Ack with drop_hit = 0 -> LOSE, lose = 1, level unchanged. Then btn_start -> IDLE, timer_rst = 1, level cleared on the next btn_start.
4. btn_pause 4 cycles into a half-period -> PAUSED; one_hz_clk frozen for 50 cycles. btn_pause again -> next toggle exactly 6 cycles after resume.
5. Raise timer_end in RUN -> LOSE exactly 3 cycles later (2 sync + 1 FSM). timer_end together with btn_pause and btn_drop in the same cycle -> LOSE, never PAUSED or DROP_WAIT.
6. Assert rst during DROP_WAIT with drop_req = 1 -> all outputs return to reset values immediately; a later drop_ack pulse leaves state = IDLE.
